// File: rtl/fft_pkg.sv
// Shared types and helpers for the FP16 8-point FFT datapath.
//   FP16_W       : width of one half-precision word
//   N_POINTS     : samples per FFT frame
//   FP16_EXP_INF : all-ones exponent (Inf/NaN)
//   fp16_t, cplx_t, bank_st_e and small FP16 classification helpers.
package fft_pkg;

  localparam int unsigned FP16_W       = 16;
  localparam int unsigned N_POINTS     = 8;
  localparam int unsigned IDX_W        = $clog2(N_POINTS);
  localparam logic [4:0]  FP16_EXP_INF = 5'd31;

  typedef logic [FP16_W-1:0] fp16_t;

  typedef struct packed {
    fp16_t re;
    fp16_t im;
  } cplx_t;

  // Life cycle of one ping-pong bank.
  typedef enum logic [1:0] {
    BkEmpty,
    BkFilling,
    BkFull,
    BkPresented
  } bank_st_e;

  function automatic logic fp16_is_inf_nan(input fp16_t w);
    return w[14:10] == FP16_EXP_INF;
  endfunction

  // Subnormals become signed zero; everything else passes through.
  function automatic fp16_t fp16_flush_subnormal(input fp16_t w);
    if (w[14:10] == 5'd0 && w[9:0] != 10'd0) begin
      return {w[15], 15'b0};
    end
    return w;
  endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// Sample-stream and frame-presentation signals of the FFT frame loader.
//   in_*    : sample stream, valid/ready handshake
//   frame_* : assembled frame towards the FFT core, valid/ready handshake
//   sync_err: pulse when a partial frame was discarded
// slave  : loader view.  master : producer/consumer (testbench) view.
interface fft_frame_loader_if;
  import fft_pkg::*;

  logic                       in_valid;
  logic                       in_ready;
  logic                       in_first;
  logic                       in_mode;
  fp16_t                      in_real;
  fp16_t                      in_imag;
  logic                       frame_valid;
  logic                       frame_ready;
  logic [N_POINTS*FP16_W-1:0] frame_real;
  logic [N_POINTS*FP16_W-1:0] frame_imag;
  logic                       frame_mode;
  logic                       frame_invalid;
  logic                       sync_err;

  modport slave (
    input  in_valid, in_first, in_mode, in_real, in_imag, frame_ready,
    output in_ready, frame_valid, frame_real, frame_imag, frame_mode, frame_invalid, sync_err
  );

  modport master (
    output in_valid, in_first, in_mode, in_real, in_imag, frame_ready,
    input  in_ready, frame_valid, frame_real, frame_imag, frame_mode, frame_invalid, sync_err
  );

endinterface

// File: rtl/fft_frame_bank.sv
// One 8-entry complex sample bank.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : empty the bank (frame consumed)
//   we_i/idx_i : write data_i at sample index idx_i
//   mode_i     : FFT/IFFT bit, latched on an index-0 write only
//   inv_i      : written sample contains an Inf/NaN word
//   real_o/imag_o/mode_o/invalid_o : stored frame contents
module fft_frame_bank
  import fft_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       we_i,
  input  logic [IDX_W-1:0]           idx_i,
  input  logic                       mode_i,
  input  cplx_t                      data_i,
  input  logic                       inv_i,
  output logic [N_POINTS*FP16_W-1:0] real_o,
  output logic [N_POINTS*FP16_W-1:0] imag_o,
  output logic                       mode_o,
  output logic                       invalid_o
);

  logic [N_POINTS*FP16_W-1:0] real_q, imag_q;
  logic                       mode_q, invalid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      real_q    <= '0;
      imag_q    <= '0;
      mode_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else if (clr_i) begin
      real_q    <= '0;
      imag_q    <= '0;
      mode_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else if (we_i) begin
      real_q[idx_i*FP16_W +: FP16_W] <= data_i.re;
      imag_q[idx_i*FP16_W +: FP16_W] <= data_i.im;
      if (idx_i == '0) begin
        // Index 0 starts a frame (also after a resync), so the flag restarts here.
        mode_q    <= mode_i;
        invalid_q <= inv_i;
      end else begin
        invalid_q <= invalid_q | inv_i;
      end
    end
  end

  assign real_o    = real_q;
  assign imag_o    = imag_q;
  assign mode_o    = mode_q;
  assign invalid_o = invalid_q;

endmodule

// File: rtl/fft_frame_loader.sv
// Assembles a stream of FP16 complex samples into 8-sample frames (natural
// order) using two ping-pong banks, and holds each frame stable until the
// FFT core accepts it.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus_io     : fft_frame_loader_if.slave (sample stream in, frame out)
// Build option FFT_LOADER_FLUSH_SUBNORMAL_EN: subnormal words are stored as
// signed zero; otherwise words are stored bit-exact.
module fft_frame_loader
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  fft_frame_loader_if.slave bus_io
);

  localparam int unsigned FrameW = N_POINTS * FP16_W;

  bank_st_e         bank_st_q [2];
  logic             wr_bank_q;
  logic             rd_bank_q;  // bank presented now, or next to be presented
  logic [IDX_W-1:0] cnt_q;
  logic             sync_err_q;

  logic             accept, resync, last_accept, frame_valid, rel_frame;
  logic [IDX_W-1:0] wr_idx;
  cplx_t            wr_data;
  logic             wr_inv;

  logic [FrameW-1:0] bank_real [2];
  logic [FrameW-1:0] bank_imag [2];
  logic              bank_mode [2];
  logic              bank_inv  [2];

  assign bus_io.in_ready = !(bank_st_q[wr_bank_q] inside {BkFull, BkPresented});

  assign accept      = bus_io.in_valid && bus_io.in_ready;
  assign resync      = accept && bus_io.in_first && (cnt_q != '0);
  assign wr_idx      = resync ? '0 : cnt_q;
  assign last_accept = accept && !resync && (cnt_q == IDX_W'(N_POINTS - 1));
  assign frame_valid = (bank_st_q[rd_bank_q] == BkPresented);
  assign rel_frame   = frame_valid && bus_io.frame_ready;

  always_comb begin
`ifdef FFT_LOADER_FLUSH_SUBNORMAL_EN
    wr_data.re = fp16_flush_subnormal(bus_io.in_real);
    wr_data.im = fp16_flush_subnormal(bus_io.in_imag);
`else
    wr_data.re = bus_io.in_real;
    wr_data.im = bus_io.in_imag;
`endif
  end

  // Flush never changes exponent 31, so the flag comes from the raw words.
  assign wr_inv = fp16_is_inf_nan(bus_io.in_real) | fp16_is_inf_nan(bus_io.in_imag);

  // Writes always target wr_bank and release/promotion always target rd_bank;
  // when both index the same bank it is FULL/PRESENTED and in_ready is low,
  // so the two updates below never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st_q[0] <= BkEmpty;
      bank_st_q[1] <= BkEmpty;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      cnt_q        <= '0;
      sync_err_q   <= 1'b0;
    end else begin
      sync_err_q <= resync;

      if (rel_frame) begin
        bank_st_q[rd_bank_q] <= BkEmpty;
        rd_bank_q            <= ~rd_bank_q;
      end else if (bank_st_q[rd_bank_q] == BkFull) begin
        bank_st_q[rd_bank_q] <= BkPresented;
      end

      if (accept) begin
        if (last_accept) begin
          bank_st_q[wr_bank_q] <= BkFull;
          wr_bank_q            <= ~wr_bank_q;
          cnt_q                <= '0;
        end else begin
          bank_st_q[wr_bank_q] <= BkFilling;
          cnt_q                <= wr_idx + IDX_W'(1);
        end
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (rel_frame && (rd_bank_q == 1'(b))),
      .we_i      (accept && (wr_bank_q == 1'(b))),
      .idx_i     (wr_idx),
      .mode_i    (bus_io.in_mode),
      .data_i    (wr_data),
      .inv_i     (wr_inv),
      .real_o    (bank_real[b]),
      .imag_o    (bank_imag[b]),
      .mode_o    (bank_mode[b]),
      .invalid_o (bank_inv[b])
    );
  end

  // Frame outputs read as zero whenever no frame is presented.
  always_comb begin
    bus_io.frame_valid   = frame_valid;
    bus_io.frame_real    = '0;
    bus_io.frame_imag    = '0;
    bus_io.frame_mode    = 1'b0;
    bus_io.frame_invalid = 1'b0;
    if (frame_valid) begin
      bus_io.frame_real    = bank_real[rd_bank_q];
      bus_io.frame_imag    = bank_imag[rd_bank_q];
      bus_io.frame_mode    = bank_mode[rd_bank_q];
      bus_io.frame_invalid = bank_inv[rd_bank_q];
    end
  end

  assign bus_io.sync_err = sync_err_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed testbench for fft_frame_loader.
module tb_fft_frame_loader;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_frame_loader_if bus ();

  fft_frame_loader dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and return #1 after the edge that accepts it.
  task automatic push(input fp16_t re, input fp16_t im, input logic first, input logic mode);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.in_real  = re;
    bus.in_imag  = im;
    bus.in_first = first;
    bus.in_mode  = mode;
    while (bus.in_ready !== 1'b1 && guard < 100) begin
      cyc();
      guard++;
    end
    if (guard >= 100) begin
      total++;
      bad++;
      $display("FAIL push_timeout in_ready=%b want 1", bus.in_ready);
    end
    cyc();
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_mode  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    total++;
    if (bus.frame_valid !== 1'b0) begin
      bad++; $display("FAIL reset_frame_valid got %b want 0", bus.frame_valid);
    end
    total++;
    if (bus.frame_real !== 128'h0 || bus.frame_imag !== 128'h0) begin
      bad++; $display("FAIL reset_frame_data got %h/%h want 0", bus.frame_real, bus.frame_imag);
    end
    total++;
    if ({bus.frame_mode, bus.frame_invalid, bus.sync_err} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got %b want 000",
                      {bus.frame_mode, bus.frame_invalid, bus.sync_err});
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_streaming();
    fp16_t pat [8];
    logic [127:0] exp_r;
    pat = '{16'h0000, 16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700};
    exp_r = '0;
    for (int k = 0; k < 8; k++) exp_r[16*k +: 16] = pat[k];
    bus.frame_ready = 1'b1;
    for (int k = 0; k < 8; k++) push(pat[k], 16'h0000, k == 0, 1'b0);
    total++;
    if (bus.frame_valid !== 1'b0) begin
      bad++; $display("FAIL stream_early_valid got %b want 0", bus.frame_valid);
    end
    cyc();
    total++;
    if (bus.frame_valid !== 1'b1) begin
      bad++; $display("FAIL stream_valid got %b want 1", bus.frame_valid);
    end
    total++;
    if (bus.frame_real[31:16] !== 16'h3C00 || bus.frame_real[127:112] !== 16'h4700) begin
      bad++; $display("FAIL stream_slices got %h,%h want 3c00,4700",
                      bus.frame_real[31:16], bus.frame_real[127:112]);
    end
    total++;
    if (bus.frame_real !== exp_r || bus.frame_imag !== 128'h0) begin
      bad++; $display("FAIL stream_frame got %h/%h want %h/0", bus.frame_real, bus.frame_imag, exp_r);
    end
    total++;
    if ({bus.frame_mode, bus.frame_invalid} !== 2'b00) begin
      bad++; $display("FAIL stream_flags got %b want 00", {bus.frame_mode, bus.frame_invalid});
    end
    cyc();
    total++;
    if (bus.frame_valid !== 1'b0) begin
      bad++; $display("FAIL stream_release got %b want 0", bus.frame_valid);
    end
  endtask

  task automatic test_back_to_back();
    time t0, t1;
    logic [127:0] exp_r;
    exp_r = '0;
    for (int k = 0; k < 8; k++) exp_r[16*k +: 16] = 16'h3100 + 16'(k);
    bus.frame_ready = 1'b1;
    t0 = $time;
    for (int k = 0; k < 16; k++) push((k < 8) ? 16'h3000 + 16'(k) : 16'h3100 + 16'(k - 8),
                                     16'(k), (k % 8) == 0, 1'b0);
    t1 = $time;
    total++;
    if (t1 - t0 !== 160) begin
      bad++; $display("FAIL b2b_elapsed got %0t want 160", t1 - t0);
    end
    cyc();
    total++;
    if (bus.frame_valid !== 1'b1 || bus.frame_real !== exp_r) begin
      bad++; $display("FAIL b2b_frame2 valid=%b got %h want %h", bus.frame_valid, bus.frame_real, exp_r);
    end
    cyc();
  endtask

  task automatic test_backpressure();
    logic [127:0] exp_a, exp_b, exp_c;
    exp_a = '0; exp_b = '0; exp_c = '0;
    for (int k = 0; k < 8; k++) begin
      exp_a[16*k +: 16] = 16'h1000 + 16'(k);
      exp_b[16*k +: 16] = 16'h2000 + 16'(k);
      exp_c[16*k +: 16] = 16'h3000 + 16'(k);
    end
    bus.frame_ready = 1'b0;
    for (int k = 0; k < 8; k++) push(16'h1000 + 16'(k), 16'h0, k == 0, 1'b0);
    for (int k = 0; k < 8; k++) push(16'h2000 + 16'(k), 16'h0, k == 0, 1'b0);
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_in_ready_drop got %b want 0", bus.in_ready);
    end
    repeat (4) cyc();
    total++;
    if (bus.in_ready !== 1'b0 || bus.frame_valid !== 1'b1 || bus.frame_real !== exp_a) begin
      bad++; $display("FAIL bp_hold ready=%b valid=%b got %h want %h",
                      bus.in_ready, bus.frame_valid, bus.frame_real, exp_a);
    end
    bus.frame_ready = 1'b1;
    cyc();
    bus.frame_ready = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_ready_after_release got %b want 1", bus.in_ready);
    end
    cyc();
    total++;
    if (bus.frame_valid !== 1'b1 || bus.frame_real !== exp_b) begin
      bad++; $display("FAIL bp_frame2 valid=%b got %h want %h", bus.frame_valid, bus.frame_real, exp_b);
    end
    for (int k = 0; k < 8; k++) push(16'h3000 + 16'(k), 16'h0, k == 0, 1'b0);
    total++;
    if (bus.frame_real !== exp_b || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_frame2_held ready=%b got %h want %h", bus.in_ready, bus.frame_real, exp_b);
    end
    bus.frame_ready = 1'b1;
    cyc();
    cyc();
    total++;
    if (bus.frame_valid !== 1'b1 || bus.frame_real !== exp_c) begin
      bad++; $display("FAIL bp_frame3 valid=%b got %h want %h", bus.frame_valid, bus.frame_real, exp_c);
    end
    cyc();
  endtask

  task automatic test_invalid_mode();
    bus.frame_ready = 1'b1;
    for (int k = 0; k < 8; k++) push(16'h3C00, (k == 5) ? 16'h7C00 : 16'h0000, k == 0, k == 0);
    cyc();
    total++;
    if ({bus.frame_valid, bus.frame_mode, bus.frame_invalid} !== 3'b111) begin
      bad++; $display("FAIL inv_mode_set got %b want 111",
                      {bus.frame_valid, bus.frame_mode, bus.frame_invalid});
    end
    cyc();
    for (int k = 0; k < 8; k++) push(16'h4000, 16'h3C00, k == 0, k != 0);
    cyc();
    total++;
    if ({bus.frame_valid, bus.frame_mode, bus.frame_invalid} !== 3'b100) begin
      bad++; $display("FAIL inv_mode_clear got %b want 100",
                      {bus.frame_valid, bus.frame_mode, bus.frame_invalid});
    end
    cyc();
  endtask

  task automatic test_resync();
    logic [127:0] exp_r;
    exp_r = '0;
    for (int k = 0; k < 8; k++) exp_r[16*k +: 16] = 16'h6000 + 16'(k);
    bus.frame_ready = 1'b1;
    for (int k = 0; k < 4; k++) push(16'h5000 + 16'(k), (k == 2) ? 16'h7E00 : 16'h0, k == 0, 1'b0);
    total++;
    if (bus.sync_err !== 1'b0) begin
      bad++; $display("FAIL resync_quiet got %b want 0", bus.sync_err);
    end
    push(16'h6000, 16'h0, 1'b1, 1'b1);
    total++;
    if (bus.sync_err !== 1'b1) begin
      bad++; $display("FAIL resync_pulse got %b want 1", bus.sync_err);
    end
    cyc();
    total++;
    if (bus.sync_err !== 1'b0) begin
      bad++; $display("FAIL resync_pulse_end got %b want 0", bus.sync_err);
    end
    for (int k = 1; k < 8; k++) push(16'h6000 + 16'(k), 16'h0, 1'b0, 1'b0);
    cyc();
    total++;
    if (bus.frame_valid !== 1'b1 || bus.frame_real !== exp_r) begin
      bad++; $display("FAIL resync_frame valid=%b got %h want %h", bus.frame_valid, bus.frame_real, exp_r);
    end
    total++;
    if ({bus.frame_mode, bus.frame_invalid} !== 2'b10) begin
      bad++; $display("FAIL resync_flags got %b want 10", {bus.frame_mode, bus.frame_invalid});
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    logic [127:0] exp_r;
    exp_r = '0;
    for (int k = 0; k < 8; k++) exp_r[16*k +: 16] = 16'h4800 + 16'(k);
    bus.frame_ready = 1'b0;
    for (int k = 0; k < 8; k++) push(16'h1111, 16'h2222, k == 0, 1'b1);
    for (int k = 0; k < 5; k++) push(16'h5555, 16'h0, k == 0, 1'b0);
    total++;
    if (bus.frame_valid !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre_valid got %b want 1", bus.frame_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.frame_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_immediate valid=%b ready=%b want 0,1", bus.frame_valid, bus.in_ready);
    end
    total++;
    if (bus.frame_real !== 128'h0 || bus.frame_mode !== 1'b0) begin
      bad++; $display("FAIL rstmid_outputs got %h mode=%b want 0", bus.frame_real, bus.frame_mode);
    end
    cyc();
    rst_n = 1'b1;
    bus.frame_ready = 1'b1;
    cyc();
    for (int k = 0; k < 8; k++) push(16'h4800 + 16'(k), 16'h0, k == 0, 1'b0);
    cyc();
    total++;
    if (bus.frame_valid !== 1'b1 || bus.frame_real !== exp_r) begin
      bad++; $display("FAIL rstmid_clean_frame valid=%b got %h want %h",
                      bus.frame_valid, bus.frame_real, exp_r);
    end
    cyc();
  endtask

  task automatic test_subnormal();
    logic [127:0] exp_r, exp_i;
    fp16_t re, im;
    exp_r = '0; exp_i = '0;
    bus.frame_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      re = (k == 0) ? 16'h0001 : (k == 1) ? 16'h8200 : (k == 3) ? 16'h8000 : 16'h3C00;
      im = (k == 2) ? 16'h03FF : 16'h0000;
      push(re, im, k == 0, 1'b0);
`ifdef FFT_LOADER_FLUSH_SUBNORMAL_EN
      if (k == 0) re = 16'h0000;
      if (k == 1) re = 16'h8000;
      if (k == 2) im = 16'h0000;
`endif
      exp_r[16*k +: 16] = re;
      exp_i[16*k +: 16] = im;
    end
    cyc();
    total++;
    if (bus.frame_valid !== 1'b1 || bus.frame_real !== exp_r || bus.frame_imag !== exp_i) begin
      bad++; $display("FAIL subnormal valid=%b got %h/%h want %h/%h",
                      bus.frame_valid, bus.frame_real, bus.frame_imag, exp_r, exp_i);
    end
    total++;
    if (bus.frame_invalid !== 1'b0) begin
      bad++; $display("FAIL subnormal_invalid got %b want 0", bus.frame_invalid);
    end
    cyc();
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_first    = 1'b0;
    bus.in_mode     = 1'b0;
    bus.in_real     = '0;
    bus.in_imag     = '0;
    bus.frame_ready = 1'b0;
    #1;
    test_reset();
    test_streaming();
    test_back_to_back();
    test_backpressure();
    test_invalid_mode();
    test_resync();
    test_reset_mid();
    test_subnormal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
